// File: rtl/latch_wr_pkg.sv
// Shared types and constants for the latch bank write controller.
// The phase counter width is derived here so the top and the timer agree on it.
package latch_wr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } wr_state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 3;
  localparam int DEF_HOLD_CYC  = 2;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Bits needed to hold the longest of the three phase lengths.
  function automatic int phase_cnt_w(input int setup_cyc, input int pulse_cyc,
                                     input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (m < 1) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/latch_bank_writer_phase_timer.sv
// Loadable down-counter timing one write phase; expired is high in the
// last cycle of the loaded phase length.
module phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Loading L makes the phase last exactly L cycles: L, L-1, ..., 1.
  assign expired = (count == CW'(1));

endmodule

// File: rtl/latch_bank_writer.sv
// Write controller for a bank of gated D latches: settles D with En low,
// pulses En, holds D, then checks the latch readback against the written word.
module latch_bank_writer
  import latch_wr_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 wr_ready,
  output logic [WIDTH-1:0]     latch_d,
  output logic                 latch_en,
  input  logic [WIDTH-1:0]     latch_q,
  output logic                 busy,
  output logic                 done,
  output logic                 verify_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2:0]           fsm_state
);

  localparam int CW = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $error("latch_bank_writer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  // Handshake: a word is accepted on a rising edge where wr_valid && wr_ready;
  // wr_ready is high only in IDLE and wr_valid/wr_data are ignored elsewhere.
  wr_state_e        state;
  wr_state_e        state_nxt;
  logic             handshake;
  logic             tmr_load;
  logic [CW-1:0]    tmr_val;
  logic             tmr_expired;
  logic [WIDTH-1:0] q_smp;

  assign wr_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign handshake  = wr_valid && wr_ready;
  assign done       = (state == CHECK);
  assign verify_err = done && (q_smp != latch_d);
  assign fsm_state  = state;

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = SETUP;
          tmr_load  = 1'b1;
          tmr_val   = CW'(SETUP_CYC);
        end
      end
      SETUP: begin
        if (tmr_expired) begin
          state_nxt = PULSE;
          tmr_load  = 1'b1;
          tmr_val   = CW'(PULSE_CYC);
        end
      end
      PULSE: begin
        if (tmr_expired) begin
          state_nxt = HOLD;
          tmr_load  = 1'b1;
          tmr_val   = CW'(HOLD_CYC);
        end
      end
      HOLD: begin
        if (tmr_expired) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch_d only moves on the handshake edge, when En is low and stays low,
  // so D and En never switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      latch_d  <= '0;
      latch_en <= 1'b0;
      q_smp    <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      latch_en <= (state_nxt == PULSE);
      if (handshake) latch_d <= wr_data;
      if (state == HOLD && tmr_expired) q_smp <= latch_q;
      if (verify_err && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
